// File: rtl/bit_serializer.sv
// bit_serializer: MSB-first parallel-to-serial front end for the XOR scrambler stage,
// with an optional even-parity bit appended after the LSB of each word.
module bit_serializer #(
    parameter int unsigned W        = 8,
    parameter int unsigned PARITY   = 0,
    parameter bit          IDLE_BIT = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         d,
    output logic         d_valid,
    output logic         frame_start,
    output logic         done
);

    localparam int unsigned   L       = W + ((PARITY != 0) ? 1 : 0);
    localparam int unsigned   CW      = $clog2(L);
    localparam logic [CW-1:0] LastCnt = CW'(L - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic          par_q, par_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic last_bit;
    logic accept;

    assign last_bit = (state_q == StShift) && (cnt_q == LastCnt);
    assign accept   = in_valid && in_ready;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            sr_q    <= '0;
            par_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: in_ready only allows an accept in idle or on the last bit,
    // so a reload always takes priority over shifting.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        par_d   = par_q;
        cnt_d   = cnt_q;
        if (accept) begin
            state_d = StShift;
            sr_d    = in_data;
            par_d   = ^in_data;
            cnt_d   = '0;
        end else if (state_q == StShift) begin
            if (!last_bit) begin
                sr_d  = {sr_q[W-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
            end else begin
                state_d = StIdle;
            end
        end
    end

    // Outputs decode from registers only, so nothing combinational reaches back upstream.
    always_comb begin
        in_ready    = (state_q == StIdle) || last_bit;
        d_valid     = (state_q == StShift);
        frame_start = d_valid && (cnt_q == '0);
        done        = last_bit;
        if (!d_valid) begin
            d = IDLE_BIT;
        end else if ((PARITY != 0) && last_bit) begin
            d = par_q;
        end else begin
            d = sr_q[W-1];
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: W=8 without parity, W=8 with parity and
// IDLE_BIT=1, and a W=2 instance for the two-bit frame corner.
module tb_bit_serializer;

    typedef struct packed {
        logic d;
        logic fs;
        logic dn;
    } item_t;

    localparam bit [1:0] IDLE = 2'b10;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] vld;
    logic [7:0] dat [2];
    wire  [1:0] rdy, ds, dv, fs, dn;

    logic       v2;
    logic [1:0] dat2;
    wire        r2, d2, dv2, fs2, dn2;

    item_t q0[$];
    item_t q1[$];
    int    acc_cnt [2];
    int    n_checks = 0;
    int    n_errors = 0;
    int    fs2_cnt = 0, dn2_cnt = 0, ov2_cnt = 0, dv2_cnt = 0;

    always #5 clk = ~clk;

    bit_serializer #(.W(8), .PARITY(0), .IDLE_BIT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(vld[0]), .in_data(dat[0]), .in_ready(rdy[0]),
        .d(ds[0]), .d_valid(dv[0]), .frame_start(fs[0]), .done(dn[0])
    );

    bit_serializer #(.W(8), .PARITY(1), .IDLE_BIT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(vld[1]), .in_data(dat[1]), .in_ready(rdy[1]),
        .d(ds[1]), .d_valid(dv[1]), .frame_start(fs[1]), .done(dn[1])
    );

    bit_serializer #(.W(2), .PARITY(0), .IDLE_BIT(1'b0)) u_dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_data(dat2), .in_ready(r2),
        .d(d2), .d_valid(dv2), .frame_start(fs2), .done(dn2)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int qsize(input int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction

    function automatic item_t qpop(input int k);
        if (k == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void qpush(input int k, input item_t it);
        if (k == 0) q0.push_back(it);
        else q1.push_back(it);
    endfunction

    // Model accept: the bench's own queue is empty exactly when the DUT is idle or on its last bit.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset && vld[k] && qsize(k) == 0) begin
                for (int i = 0; i < 8; i++) begin
                    item_t it;
                    it.d  = dat[k][7-i];
                    it.fs = (i == 0);
                    it.dn = (k == 0) && (i == 7);
                    qpush(k, it);
                end
                if (k == 1) begin
                    item_t it;
                    it.d  = ^dat[k];
                    it.fs = 1'b0;
                    it.dn = 1'b1;
                    qpush(k, it);
                end
                acc_cnt[k]++;
            end
        end
    end

    task automatic mon(input int k);
        item_t it;
        bit    have;
        have = (qsize(k) != 0);
        it   = have ? qpop(k) : item_t'(3'b000);
        check_eq($sformatf("u%0d.d_valid", k), 32'(dv[k]), 32'(have));
        check_eq($sformatf("u%0d.d", k), 32'(ds[k]), have ? 32'(it.d) : 32'(IDLE[k]));
        check_eq($sformatf("u%0d.frame_start", k), 32'(fs[k]), 32'(have && it.fs));
        check_eq($sformatf("u%0d.done", k), 32'(dn[k]), 32'(have && it.dn));
        check_eq($sformatf("u%0d.in_ready", k), 32'(rdy[k]), have ? 32'(it.dn) : 32'd1);
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) mon(k);
    end

    always @(negedge clk) begin
        dat2 = 2'($urandom);
        if (reset) begin
            if (fs2 && dn2) ov2_cnt++;
            if (fs2) fs2_cnt++;
            if (dn2) dn2_cnt++;
            if (dv2) dv2_cnt++;
        end
    end

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("u%0d.rst_d_valid", k), 32'(dv[k]), 32'd0);
            check_eq($sformatf("u%0d.rst_d", k), 32'(ds[k]), 32'(IDLE[k]));
            check_eq($sformatf("u%0d.rst_frame_start", k), 32'(fs[k]), 32'd0);
            check_eq($sformatf("u%0d.rst_done", k), 32'(dn[k]), 32'd0);
            check_eq($sformatf("u%0d.rst_in_ready", k), 32'(rdy[k]), 32'd1);
        end
        q0.delete();
        q1.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_acc(input int k, input int a);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (acc_cnt[k] != a) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq($sformatf("u%0d.accept", k), 32'(ok), 32'd1);
    endtask

    // Leaves in_valid high so a following send is back-to-back.
    task automatic send(input int k, input logic [7:0] w);
        int a;
        a      = acc_cnt[k];
        vld[k] = 1'b1;
        dat[k] = w;
        wait_acc(k, a);
    endtask

    task automatic drain(input int k);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (qsize(k) == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq($sformatf("u%0d.drain", k), 32'(ok), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int a;
        vld        = '0;
        dat[0]     = '0;
        dat[1]     = '0;
        v2         = 1'b0;
        acc_cnt[0] = 0;
        acc_cnt[1] = 0;
        #2;
        apply_reset();

        // Two-bit frames streamed continuously
        v2 = 1'b1;
        repeat (20) @(negedge clk);
        v2 = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("w2.start_done_overlap", 32'(ov2_cnt), 32'd0);
        check_eq("w2.start_vs_done", 32'(dn2_cnt), 32'(fs2_cnt));
        check_eq("w2.enough_frames", 32'(fs2_cnt >= 5), 32'd1);
        check_eq("w2.valid_cycles", 32'(dv2_cnt), 32'(2 * fs2_cnt));

        send(0, 8'hA5);
        vld[0] = 1'b0;
        drain(0);

        send(0, 8'hA5);
        send(0, 8'h3C);
        vld[0] = 1'b0;
        drain(0);

        send(1, 8'h07);
        vld[1] = 1'b0;
        drain(1);
        send(1, 8'h03);
        vld[1] = 1'b0;
        drain(1);

        // Hold-off: word offered mid-frame, changed before the last-bit edge
        send(0, 8'hA5);
        vld[0] = 1'b0;
        repeat (2) @(negedge clk);
        a      = acc_cnt[0];
        vld[0] = 1'b1;
        dat[0] = 8'hFF;
        repeat (3) @(negedge clk);
        dat[0] = 8'h81;
        wait_acc(0, a);
        vld[0] = 1'b0;
        drain(0);

        // Abort a frame after three bits
        send(0, 8'hF0);
        vld[0] = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2;
        apply_reset();
        send(0, 8'h5A);
        vld[0] = 1'b0;
        drain(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Parallel-to-serial front end for the two-flop XOR scrambler stage. It accepts W-bit words over a valid/ready handshake and shifts each word out MSB-first, one bit per clock, on `d`. An even-parity bit can be appended to each word. `d` drives the scrambler's serial input `d` directly. Back-to-back words are emitted with no idle gap.

## Interface
- `W`, default 8: data word width; must be ≥ 2.
- `PARITY`, default 0: 1 appends an even-parity bit after the LSB.
- `IDLE_BIT`, default 0: value driven on `d` when no frame is active.

Frame length is L = W + PARITY.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_data`  in  W  upstream word; sampled only on the accept edge.
- `in_ready`  out  1  block can accept a word this cycle.
- `d`  out  1  serial bit to the scrambler.
- `d_valid`  out  1  `d` carries a frame bit this cycle.
- `frame_start`  out  1  one-cycle pulse on a frame's first bit.
- `done`  out  1  one-cycle pulse on a frame's last bit.

## Operation
- State: FSM {IDLE, SHIFT}, W-bit shift register `sr`, parity flag `par`, bit counter `cnt` (0..L-1, width $clog2(L)).
- Accept: occurs on an edge where `in_valid && in_ready`.
- On accept:
  - `sr` ← `in_data`; `par` ← ^`in_data`; `cnt` ← 0; state ← SHIFT.
- In SHIFT, the output bit is `sr[W-1]` for `cnt` < W, and `par` for `cnt` == W (PARITY=1 only).
- Each edge in SHIFT with `cnt` < L-1: shift `sr` left by one and increment `cnt`.
- Edge in SHIFT with `cnt` == L-1:
  - Accept present: reload as above and stay in SHIFT.
  - No accept: state ← IDLE.
- Output decode (all combinational from registers only, with no path from `in_valid` or `in_data`):
  - `in_ready` = (state==IDLE) || (state==SHIFT && `cnt`==L-1).
  - `d_valid` = (state==SHIFT).
  - `d` = `d_valid` ? current frame bit : `IDLE_BIT`.
  - `frame_start` = `d_valid` && `cnt`==0.
  - `done` = `d_valid` && `cnt`==L-1.
- While `in_ready` is 0, `in_valid` and `in_data` are ignored. Upstream holds them under normal valid/ready rules.
- Reset (`reset` low):
  - State → IDLE; `sr`, `par`, `cnt` → 0.
  - Outputs: `d_valid`=0, `d`=`IDLE_BIT`, `frame_start`=0, `done`=0, `in_ready`=1.
  - No accept occurs while `reset` is low.
- Reset mid-frame: the frame is aborted immediately and asynchronously, with no `done` pulse. The partial frame is discarded, and the first accept after release starts a fresh frame at `cnt`=0.

## Timing
- Latency: accept at edge k → first bit on `d` (with `frame_start`) in the cycle after edge k.
- Last bit and `done` appear in the cycle after edge k+L-1.
- Throughput: one frame per L cycles with `in_valid` held high. `d_valid` stays continuously high across frames.
- Idle gap: if no word is offered on the last-bit edge, `d_valid` is 0 for at least one cycle before the next frame.
- L=2 edge case (W=2, PARITY=0): `frame_start` and `done` are never in the same cycle.
- Reset release: the first accept can occur on the first rising edge at which `reset` is high.

## Test plan
- Reset: drive `reset` low mid-stream. Require `d_valid`=0, `d`=`IDLE_BIT`, `frame_start`=0, `done`=0, `in_ready`=1 without waiting for a clock edge.
- Single word, W=8, PARITY=0, `in_data`=8'hA5. Require:
  - `d` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles.
  - `frame_start` on bit 1 and `done` on bit 8.
  - Then `d_valid`=0 and `d`=0.
- Back-to-back 8'hA5 then 8'h3C with `in_valid` held. Require:
  - 16 contiguous valid bits: 10100101 00111100.
  - `in_ready` high only at the idle accept and on bit 8.
  - Two `frame_start` and two `done` pulses.
- PARITY=1, `in_data`=8'h07: require 9 bits 0,0,0,0,0,1,1,1,1 (parity=1), with `done` on bit 9. Repeat with 8'h03: parity bit 0.
- Hold-off: offer 8'hFF while `cnt`=2, then change `in_data` to 8'h81 before the last-bit edge. Require that only 8'h81 is accepted, on the last-bit edge.
- Reset mid-frame after 3 bits of 8'hF0. Require:
  - `d_valid` drops immediately and no `done` pulse occurs.
  - After release, 8'h5A serializes fully as 0,1,0,1,1,0,1,0.
